// File: rtl/calc_cmd_sched.sv
// calc_cmd_sched: arbitrates two command streams onto a single calculator,
// keeping the calculator with one requester until its expression ends.
module calc_cmd_sched #(
  parameter int unsigned TIMEOUT  = 1023,
  parameter logic [3:0]  IDLE_CMD = 4'hD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [3:0] req0_cmd,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_cmd,
  output logic       req1_ready,
  input  logic [1:0] calc_status,
  output logic [3:0] calc_cmd,
  output logic       calc_rst,
  output logic       owner,
  output logic       locked,
  output logic       busy,
  output logic       err_pulse,
  output logic [1:0] err_code
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [1:0] ST_ERR = 2'b00;
  localparam logic [1:0] ST_RDY = 2'b10;
  localparam logic [3:0] CMD_EQ = 4'hE;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_READY, ABORT
  } state_t;

  state_t        state;
  logic          rr;
  logic [3:0]    cmd_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          cand;
  logic          take;
  logic          stat_err;
  logic          stat_rdy;
  logic          tmo;

  assign stat_err = calc_status == ST_ERR;
  assign stat_rdy = calc_status == ST_RDY;

  // A held lock overrides both the single-valid rule and rr.
  always_comb begin
    cand = rr;
    if (locked)
      cand = owner;
    else if (req0_valid != req1_valid)
      cand = req1_valid;
  end

  assign take = !reset && state == IDLE && stat_rdy &&
                (cand ? req1_valid : req0_valid);
  assign req0_ready = take && !cand;
  assign req1_ready = take && cand;
  assign busy = state != IDLE;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign tmo = cnt_inc >= CNT_MAX;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      calc_cmd  <= IDLE_CMD;
      calc_rst  <= 1'b0;
      owner     <= 1'b0;
      locked    <= 1'b0;
      rr        <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= 2'b00;
      cnt       <= '0;
      cmd_q     <= IDLE_CMD;
    end else begin
      calc_cmd  <= IDLE_CMD;
      calc_rst  <= 1'b0;
      err_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (stat_err) begin
            state     <= ABORT;
            calc_rst  <= 1'b1;
            err_pulse <= 1'b1;
            err_code  <= 2'b01;
            locked    <= 1'b0;
            rr        <= ~owner;
          end else if (take) begin
            cmd_q    <= cand ? req1_cmd : req0_cmd;
            calc_cmd <= cand ? req1_cmd : req0_cmd;
            owner    <= cand;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_READY: begin
          cnt <= cnt_inc;
          if (stat_err || tmo) begin
            state     <= ABORT;
            calc_rst  <= 1'b1;
            err_pulse <= 1'b1;
            err_code  <= stat_err ? 2'b01 : 2'b10;
            locked    <= 1'b0;
            rr        <= ~owner;
          end else if (state == WAIT_BUSY) begin
            if (!stat_rdy)
              state <= WAIT_READY;
          end else if (stat_rdy) begin
            state  <= IDLE;
            locked <= cmd_q != CMD_EQ;
            if (cmd_q == CMD_EQ)
              rr <= ~owner;
          end
        end
        ABORT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_cmd_sched.sv
// tb_calc_cmd_sched: directed and random stimulus against a
// transaction-level model of the two-requester calculator scheduler.
module tb_calc_cmd_sched;

  localparam int TMO = 8;
  localparam int P_IDLE = 0, P_ISS = 1, P_WB = 2, P_WR = 3, P_ABT = 4;

  logic       clock, reset;
  logic       v0, v1;
  logic [3:0] c0, c1;
  logic [1:0] st;
  logic       req0_ready, req1_ready;
  logic [3:0] calc_cmd;
  logic       calc_rst, owner, locked, busy, err_pulse;
  logic [1:0] err_code;

  calc_cmd_sched #(.TIMEOUT(TMO), .IDLE_CMD(4'hD)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(v0), .req0_cmd(c0), .req0_ready(req0_ready),
    .req1_valid(v1), .req1_cmd(c1), .req1_ready(req1_ready),
    .calc_status(st), .calc_cmd(calc_cmd), .calc_rst(calc_rst),
    .owner(owner), .locked(locked), .busy(busy),
    .err_pulse(err_pulse), .err_code(err_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nchk = 0, nerr = 0;

  // reference model: one outstanding command and its wait count
  int         ph, m_cnt;
  bit         m_owner, m_locked, m_rr;
  logic [3:0] m_cmd;
  logic [1:0] m_ecode;
  bit         acc0, acc1;

  // stimulus state
  bit [3:0]   q0[$], q1[$];
  logic [4:0] issued[$];
  int         mode, cb, cyc, nrst, t_issue, t_abort;
  bit         err_once;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit mcand();
    if (m_locked) return m_owner;
    if (v0 != v1) return v1;
    return m_rr;
  endfunction

  task automatic mreset();
    ph = P_IDLE; m_cnt = 0; m_owner = 0; m_locked = 0; m_rr = 0;
    m_cmd = 4'hD; m_ecode = 2'b00; acc0 = 0; acc1 = 0; cb = 0;
  endtask

  task automatic mabort(input logic [1:0] e);
    ph = P_ABT; m_ecode = e; m_locked = 0; m_rr = !m_owner;
  endtask

  task automatic mcheck();
    bit c, t;
    c = mcand();
    t = (ph == P_IDLE) && (st == 2'b10) && (c ? v1 : v0);
    chk("req0_ready", req0_ready, t && !c);
    chk("req1_ready", req1_ready, t && c);
    chk("calc_cmd", calc_cmd, ph == P_ISS ? m_cmd : 4'hD);
    chk("calc_rst", calc_rst, ph == P_ABT);
    chk("err_pulse", err_pulse, ph == P_ABT);
    chk("busy", busy, ph != P_IDLE);
    chk("owner", owner, m_owner);
    chk("locked", locked, m_locked);
    chk("err_code", err_code, m_ecode);
  endtask

  task automatic mstep();
    bit c;
    c = mcand();
    acc0 = 0; acc1 = 0;
    case (ph)
      P_IDLE:
        if (st == 2'b00) mabort(2'b01);
        else if (st == 2'b10 && (c ? v1 : v0)) begin
          m_cmd = c ? c1 : c0; m_owner = c; ph = P_ISS;
          if (c) acc1 = 1; else acc0 = 1;
        end
      P_ISS: begin ph = P_WB; m_cnt = 0; end
      P_WB, P_WR: begin
        m_cnt++;
        if (st == 2'b00) mabort(2'b01);
        else if (m_cnt >= TMO) mabort(2'b10);
        else if (ph == P_WB) begin
          if (st != 2'b10) ph = P_WR;
        end else if (st == 2'b10) begin
          ph = P_IDLE;
          if (m_cmd == 4'hE) begin m_locked = 0; m_rr = !m_owner; end
          else m_locked = 1;
        end
      end
      default: ph = P_IDLE;
    endcase
  endtask

  task automatic gen(input int n);
    int k, o;
    bit [3:0] x;
    k = $urandom_range(0, 3);
    for (int i = 0; i <= 2 * k + 1; i++) begin
      o = $urandom_range(0, 3);
      if (i == 2 * k + 1) x = 4'hE;
      else if (i % 2 == 0) x = 4'($urandom_range(0, 9));
      else x = (o == 3) ? 4'hF : 4'(4'hA + o);
      if (n == 0) q0.push_back(x); else q1.push_back(x);
    end
  endtask

  task automatic drive();
    if (acc0) begin void'(q0.pop_front()); v0 = 0; end
    if (acc1) begin void'(q1.pop_front()); v1 = 0; end
    if (mode == 0) begin
      if (q0.size() == 0) gen(0);
      if (q1.size() == 0) gen(1);
      if (!v0) v0 = 1'($urandom_range(0, 1));
      if (!v1) v1 = 1'($urandom_range(0, 1));
    end else begin
      v0 = q0.size() > 0;
      v1 = q1.size() > 0;
    end
    c0 = v0 ? q0[0] : 4'($urandom);
    c1 = v1 ? q1[0] : 4'($urandom);
    if (calc_rst === 1'b1) cb = 0;
    if (calc_cmd !== 4'hD)
      cb = (mode != 0) ? 4 :
           ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(2, 4);
    if (mode == 3)
      st = (ph == P_IDLE) ? 2'b10 : 2'b01;
    else if ((ph == P_WB || ph == P_WR) &&
             ((mode == 0 && $urandom_range(0, 29) == 0) ||
              (mode == 2 && ph == P_WR && err_once))) begin
      st = 2'b00; cb = 0; err_once = 0;
    end else if (cb > 0) begin
      st = 2'b01; cb--;
    end else st = 2'b10;
  endtask

  task automatic tick();
    #1;
    mcheck();
    if (calc_cmd !== 4'hD) begin
      issued.push_back({owner, calc_cmd});
      t_issue = cyc;
    end
    if (calc_rst === 1'b1) begin nrst++; t_abort = cyc; end
    mstep();
    cyc++;
    @(negedge clock);
  endtask

  task automatic rchk(input string p);
    chk({p, "_req0_ready"}, req0_ready, 0);
    chk({p, "_req1_ready"}, req1_ready, 0);
    chk({p, "_calc_cmd"}, calc_cmd, 4'hD);
    chk({p, "_calc_rst"}, calc_rst, 0);
    chk({p, "_owner"}, owner, 0);
    chk({p, "_locked"}, locked, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_err_pulse"}, err_pulse, 0);
    chk({p, "_err_code"}, err_code, 2'b00);
  endtask

  logic [4:0] exp_seq [8];
  int n;

  initial begin
    exp_seq = '{5'h01, 5'h0A, 5'h02, 5'h0E, 5'h15, 5'h1E, 5'h03, 5'h0E};
    reset = 0; v0 = 1; v1 = 1; c0 = 4'h1; c1 = 4'h5; st = 2'b10;
    mode = 1; cyc = 0; nrst = 0; err_once = 0;
    mreset();
    #1 reset = 1;
    #2 rchk("reset");
    @(negedge clock);
    reset = 0;

    // req0 holds 1,A,2,E,3,E and req1 holds 5,E, both always valid
    q0 = '{4'h1, 4'hA, 4'h2, 4'hE, 4'h3, 4'hE};
    q1 = '{4'h5, 4'hE};
    issued.delete();
    for (int i = 0; i < 300 && !(issued.size() >= 8 && ph == P_IDLE); i++) begin
      drive(); tick();
    end
    chk("order_count", issued.size(), 8);
    for (int i = 0; i < 8; i++) chk("order_entry", issued[i], exp_seq[i]);

    // calculator error while waiting for ready
    mode = 2; err_once = 1; nrst = 0; q0.push_back(4'h7);
    n = 0;
    while (n < 60 && !(nrst == 1 && ph == P_IDLE)) begin
      drive(); tick(); n++;
    end
    repeat (3) begin drive(); tick(); end
    chk("err_rst_pulses", nrst, 1);
    chk("err_code_calc", err_code, 2'b01);

    // calculator stuck busy until the timeout fires
    mode = 3; t_issue = -1; t_abort = -1; q0.push_back(4'h8);
    n = 0;
    while (n < 60 && !(t_abort >= 0 && ph == P_IDLE)) begin
      drive(); tick(); n++;
    end
    chk("tmo_cycles", t_abort - t_issue - 1, TMO);
    chk("tmo_err_code", err_code, 2'b10);

    // reset while waiting for the calculator to go busy
    mode = 1; q0.push_back(4'h9);
    n = 0;
    while (n < 30 && ph != P_WB) begin drive(); tick(); n++; end
    chk("reach_wait_busy", busy, 1);
    v0 = 1; v1 = 1; st = 2'b10;
    reset = 1;
    #1 rchk("midreset");
    @(posedge clock);
    #1 chk("midreset_no_rst", calc_rst, 0);
    @(negedge clock);
    reset = 0;
    mreset();
    q0.delete(); q1.delete();
    q0.push_back(4'h4); q0.push_back(4'hE);
    v0 = 0; v1 = 0;
    drive();
    #1 chk("first_accept", req0_ready, 1);
    tick();
    for (int i = 0; i < 20; i++) begin drive(); tick(); end

    // random traffic
    mode = 0; v0 = 0; v1 = 0;
    for (int i = 0; i < 3000; i++) begin drive(); tick(); end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
